// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: MIPS ID decode carried through STAGES control pipeline registers,
// with load-use bubble insertion, hold, ID/EX flush and a saturating bubble counter.
module pipelined_control_unit #(
   parameter int CTRL_W    = 27,
   parameter int STAGES    = 3,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              instruction,
   input  logic                     instr_valid,
   input  logic                     hold,
   input  logic                     flush,
   output logic [STAGES*CTRL_W-1:0] ctrl_pipe,
   output logic [STAGES*5-1:0]      dest_pipe,
   output logic                     stall_out,
   output logic [CNT_W-1:0]         bubble_cnt
);
   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd, sh;
   logic [26:0] ctrl_d;
   logic [4:0] dest_d;
   logic uses_rs, uses_rt, hz, bub;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [CTRL_W-1:0] ctrl_q [STAGES];
   logic [4:0] dest_q [STAGES];
   assign {op, rs, rt, rd, sh, fn} = instruction;
   always_comb begin
      ctrl_d  = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (op)
         6'h00: if (sh == 5'd0) case (fn)
            6'h23: begin ctrl_d[15:13] = 3'b001; ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b11; ctrl_d[10:8] = 3'b100; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h08: begin ctrl_d[1] = 1'b1; ctrl_d[12] = 1'b1; uses_rs = 1'b1; end
            6'h10: begin ctrl_d[10:8] = 3'b001; ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b11; end
            6'h12: begin ctrl_d[10:8] = 3'b010; ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b11; end
            default: ;
         endcase
         6'h09: begin ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b01; ctrl_d[10:8] = 3'b100; uses_rs = 1'b1; end
         6'h24: begin ctrl_d[22] = 1'b1; ctrl_d[26] = 1'b1; ctrl_d[7:6] = 2'b01; ctrl_d[17] = 1'b1; ctrl_d[19:18] = 2'b01; ctrl_d[10:8] = 3'b100; uses_rs = 1'b1; end
         6'h28: begin ctrl_d[16] = 1'b1; ctrl_d[17] = 1'b1; ctrl_d[19:18] = 2'b01; ctrl_d[10:8] = 3'b100; uses_rs = 1'b1; uses_rt = 1'b1; end
         6'h07: begin ctrl_d[15:13] = 3'b100; ctrl_d[2] = 1'b1; uses_rs = 1'b1; end
         6'h0F: begin ctrl_d[15:13] = 3'b110; ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b01; ctrl_d[10:8] = 3'b100; end
         6'h03: begin ctrl_d[1] = 1'b1; ctrl_d[3] = 1'b1; ctrl_d[22] = 1'b1; ctrl_d[7:6] = 2'b10; ctrl_d[25] = 1'b1; end
         6'h02: ctrl_d[1] = 1'b1;
         default: ;
      endcase
      // every decoded instruction sets at least one field, so any set bit marks it valid
      ctrl_d[4] = |ctrl_d;
      dest_d = ctrl_d[7:6] == 2'b01 ? rt : ctrl_d[7:6] == 2'b11 ? rd : ctrl_d[7:6] == 2'b10 ? 5'd31 : 5'd0;
      hz = (HAZARD_EN != 0) && instr_valid && ctrl_q[0][26] && dest_q[0] != 5'd0 &&
           ((dest_q[0] == rs && uses_rs) || (dest_q[0] == rt && uses_rt));
      bub = flush | hz | ~instr_valid;
      cnt_d = (hz && !flush && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            ctrl_q[i] <= '0;
            dest_q[i] <= '0;
         end
         cnt_q <= '0;
      end else if (!hold) begin
         for (int i = STAGES - 1; i > 0; i--) begin
            ctrl_q[i] <= ctrl_q[i-1];
            dest_q[i] <= dest_q[i-1];
         end
         ctrl_q[0] <= bub ? '0 : CTRL_W'(ctrl_d);
         dest_q[0] <= bub ? 5'd0 : dest_d;
         cnt_q     <= cnt_d;
      end
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_out
      assign ctrl_pipe[k*CTRL_W +: CTRL_W] = ctrl_q[k];
      assign dest_pipe[k*5 +: 5]           = dest_q[k];
   end
   assign stall_out  = hz & ~hold;
   assign bubble_cnt = cnt_q;
endmodule
